// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
//   state_t  : controller states (IDLE / RUN / DONE)
//   FLAG_*   : bit positions inside the 4-bit flags output
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLAG_W = 4;
    localparam int FLAG_C = 0;   // carry-out of MSB (for subtract: 1 = no borrow)
    localparam int FLAG_V = 1;   // signed overflow
    localparam int FLAG_Z = 2;   // result is zero
    localparam int FLAG_N = 3;   // result MSB

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
//   a, b, cin : addend bits and carry-in
//   sum, cout : sum bit and carry-out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock through a single
// full adder cell. Valid/ready handshake on both operand and result sides.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (a, b, sub sampled on accept)
//   a, b, sub             : operands, sub=1 selects a-b, sub=0 selects a+b
//   out_valid / out_ready : result handshake
//   result, flags         : sum/difference and {N, Z, V, C}; zero outside DONE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// RUN   | one operand bit per edge, WIDTH edges total
// DONE  | result/flags presented, held until out_ready
module serial_addsub_ctrl
    import addsub_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [FLAG_W-1:0] flags
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   res_sh;
    logic               sub_q;
    logic               carry_q;
    logic               cin_msb_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_bit;
    logic               fa_b;
    logic               fa_sum;
    logic               fa_cout;

    assign last_bit = (cnt_q == LAST_BIT);

    // Subtraction is a + ~b + 1: invert b per bit, the +1 enters as initial carry.
    assign fa_b = b_sh[0] ^ sub_q;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (fa_b),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_bit)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            cin_msb_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh      <= a;
                        b_sh      <= b;
                        sub_q     <= sub;
                        carry_q   <= sub;
                        cin_msb_q <= 1'b0;
                        res_sh    <= '0;
                        cnt_q     <= '0;
                    end
                end
                RUN: begin
                    // Sum bits enter at the MSB so that after WIDTH shifts
                    // bit 0 has travelled down to result[0].
                    res_sh  <= {fa_sum, res_sh[WIDTH-1:1]};
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    // Carry into the MSB, needed for signed overflow.
                    if (last_bit) begin
                        cin_msb_q <= carry_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        result    = '0;
        flags     = '0;
        if (state_q == DONE) begin
            result         = res_sh;
            flags[FLAG_C]  = carry_q;
            flags[FLAG_V]  = cin_msb_q ^ carry_q;
            flags[FLAG_Z]  = ~|res_sh;
            flags[FLAG_N]  = res_sh[WIDTH-1];
        end
    end

endmodule
